// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared definitions for the data_memory block.
//   - FSM state encodings (MEM_S_IDLE / MEM_S_BUSY / MEM_S_DONE)
//   - latched operation encoding
//   - default ADDR_WIDTH / LATENCY values used by the top level
//   - misalignment helper used when DATA_MEMORY_ALIGN_CHECK_EN is defined
package data_memory_pkg;

  localparam int DM_ADDR_WIDTH_DEFAULT = 10;
  localparam int DM_LATENCY_DEFAULT    = 3;
  // LATENCY is limited to 1..15, so the countdown fits in 4 bits.
  localparam int DM_CNT_W              = 4;

  typedef enum logic [1:0] {
    MEM_S_IDLE = 2'd0,
    MEM_S_BUSY = 2'd1,
    MEM_S_DONE = 2'd2
  } mem_state_e;

  typedef enum logic {
    MEM_OP_READ  = 1'b0,
    MEM_OP_WRITE = 1'b1
  } mem_op_e;

  // True when the byte offset inside a word is nonzero.
  function automatic logic addr_misaligned(input logic [1:0] byte_off);
    return (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/data_memory_ram_array.sv
// ram_array: plain synchronous single-port 32-bit word array.
//   clk   : clock
//   rst   : async active-high reset, clears only the read-data register
//   we    : write enable, array[addr] <= wdata on the rising edge
//   re    : read enable, rdata <= array[addr] on the rising edge
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, held while re is low
// Array contents are never reset.
module ram_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_r [0:(1 << ADDR_WIDTH)-1];

  // Storage write port; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Registered read port; holds the last word until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= 32'h0000_0000;
    end else if (re) begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/data_memory.sv
// data_memory: word-addressed data RAM serving the CPU memory stage.
// A load/store is accepted in IDLE, held for LATENCY cycles in BUSY, then
// performed; completion is signalled by one-cycle pulses, followed by one
// DONE cycle in which inputs are ignored.
//   clk              : clock, all state changes on the rising edge
//   rst              : async active-high reset (aborts any pending access)
//   mem_addr         : byte address; word index = addr[ADDR_WIDTH+1:2]
//   mem_write_data   : store data
//   mem_write_enable : store request (wins over a simultaneous load)
//   mem_read_enable  : load request
//   mem_read_data    : last word read, held between reads
//   mem_data_ready   : one-cycle pulse when a read completes
//   mem_done         : one-cycle pulse when any access completes
//   mem_fault        : only with DATA_MEMORY_ALIGN_CHECK_EN; pulses with
//                      mem_done when the request address was not word
//                      aligned (the access itself is then suppressed)
module data_memory #(
  parameter int ADDR_WIDTH = data_memory_pkg::DM_ADDR_WIDTH_DEFAULT,
  parameter int LATENCY    = data_memory_pkg::DM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  input  logic        mem_write_enable,
  input  logic        mem_read_enable,
  output logic [31:0] mem_read_data,
  output logic        mem_data_ready,
  output logic        mem_done
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
  ,
  output logic        mem_fault
`endif
);

  import data_memory_pkg::*;

  localparam logic [DM_CNT_W-1:0] CNT_LOAD = DM_CNT_W'(LATENCY - 1);

  mem_state_e            state_r;
  mem_state_e            state_next_s;
  logic [DM_CNT_W-1:0]   count_r;
  logic [DM_CNT_W-1:0]   count_next_s;
  logic [ADDR_WIDTH-1:0] idx_r;
  logic [31:0]           wdata_r;
  mem_op_e               op_r;
  logic                  fault_r;
  logic                  req_fault_s;
  logic                  accept_s;
  logic                  access_s;
  logic                  done_next_s;
  logic                  ready_next_s;
  logic                  ram_we_s;
  logic                  ram_re_s;
  logic                  unused_addr_s;

`ifdef DATA_MEMORY_ALIGN_CHECK_EN
  assign req_fault_s = addr_misaligned(mem_addr[1:0]);
`else
  assign req_fault_s = 1'b0;
`endif

  // Byte offset and bits above the array wrap are intentionally ignored.
  assign unused_addr_s = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

  // Next-state, countdown and completion decode.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    accept_s     = 1'b0;
    access_s     = 1'b0;
    done_next_s  = 1'b0;
    ready_next_s = 1'b0;
    case (state_r)
      MEM_S_IDLE: begin
        if (mem_write_enable || mem_read_enable) begin
          accept_s     = 1'b1;
          count_next_s = CNT_LOAD;
          state_next_s = MEM_S_BUSY;
        end else begin
          state_next_s = MEM_S_IDLE;
        end
      end
      MEM_S_BUSY: begin
        if (count_r != {DM_CNT_W{1'b0}}) begin
          count_next_s = count_r - {{(DM_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          access_s     = 1'b1;
          done_next_s  = 1'b1;
          ready_next_s = (op_r == MEM_OP_READ);
          state_next_s = MEM_S_DONE;
        end
      end
      MEM_S_DONE: begin
        state_next_s = MEM_S_IDLE;
      end
      default: begin
        state_next_s = MEM_S_IDLE;
      end
    endcase
  end

  // A faulted request still completes but never touches the array.
  assign ram_we_s = access_s && (op_r == MEM_OP_WRITE) && !fault_r;
  assign ram_re_s = access_s && (op_r == MEM_OP_READ)  && !fault_r;

  // FSM state, countdown and completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= MEM_S_IDLE;
      count_r        <= {DM_CNT_W{1'b0}};
      mem_done       <= 1'b0;
      mem_data_ready <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      count_r        <= count_next_s;
      mem_done       <= done_next_s;
      mem_data_ready <= ready_next_s;
    end
  end

  // Request capture at acceptance; inputs are ignored until back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r   <= {ADDR_WIDTH{1'b0}};
      wdata_r <= 32'h0000_0000;
      op_r    <= MEM_OP_READ;
      fault_r <= 1'b0;
    end else if (accept_s) begin
      idx_r   <= mem_addr[ADDR_WIDTH+1:2];
      wdata_r <= mem_write_data;
      op_r    <= mem_write_enable ? MEM_OP_WRITE : MEM_OP_READ;
      fault_r <= req_fault_s;
    end
  end

`ifdef DATA_MEMORY_ALIGN_CHECK_EN
  // Fault pulse aligned with mem_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_fault <= 1'b0;
    end else begin
      mem_fault <= done_next_s && fault_r;
    end
  end
`endif

  ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram_array (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we_s),
    .re   (ram_re_s),
    .addr (idx_r),
    .wdata(wdata_r),
    .rdata(mem_read_data)
  );

endmodule
